// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the character-LCD sequencer: FSM states, bus addresses, HD44780 opcodes.
package lcd_seq_pkg;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_INIT_ISSUE,
        ST_INIT_BUS,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_ISSUE,
        ST_POLL,
        ST_BUS,
        ST_WAIT
    } seq_state_t;

    typedef enum logic [1:0] {
        BC_IDLE,
        BC_SETUP,
        BC_PULSE,
        BC_GAP
    } bus_state_t;

    localparam logic [1:0] ADDR_CMD_WR    = 2'd0;
    localparam logic [1:0] ADDR_STATUS_RD = 2'd1;
    localparam logic [1:0] ADDR_DATA_WR   = 2'd2;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
    localparam logic [7:0] LCD_DDRAM_L0    = 8'h80;
    localparam logic [7:0] LCD_DDRAM_L1    = 8'hC0;
    localparam logic [7:0] CHAR_NEWLINE    = 8'h0A;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = LCD_CMD_FUNCSET;
            2'd1:    init_cmd = LCD_CMD_DISPON;
            2'd2:    init_cmd = LCD_CMD_CLEAR;
            default: init_cmd = LCD_CMD_ENTRY;
        endcase
    endfunction

    function automatic logic [7:0] ddram_cmd(input logic line);
        ddram_cmd = line ? LCD_DDRAM_L1 : LCD_DDRAM_L0;
    endfunction

    function automatic logic is_home_cmd(input logic [7:0] cmd);
        is_home_cmd = (cmd == LCD_CMD_CLEAR) || (cmd == LCD_CMD_HOME);
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One timed LCD bus access: SETUP (1 cycle), PULSE (E high), GAP (E low, address/data held).
// done is high on the last GAP cycle; status holds readdata[7] sampled on the last PULSE cycle.
module lcd_bus_cycle
    import lcd_seq_pkg::*;
#(
    parameter int unsigned E_HIGH_CYCLES = 12,
    parameter int unsigned E_GAP_CYCLES  = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rd_nwr,
    input  logic [1:0] addr,
    input  logic [7:0] data,
    output logic       done,
    output logic       status,
    output logic [1:0] avm_address,
    output logic       avm_read,
    output logic       avm_write,
    output logic       avm_begintransfer,
    output logic [7:0] avm_writedata,
    input  logic [7:0] avm_readdata
);

    bus_state_t  state_q;
    logic [31:0] cnt_q;
    logic        rd_q;
    logic [1:0]  address_q;
    logic [7:0]  writedata_q;
    logic        read_q;
    logic        write_q;
    logic        bt_q;
    logic        status_q;

    // Only the busy flag of the status byte matters here.
    logic unused_status_bits;
    assign unused_status_bits = ^avm_readdata[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BC_IDLE;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            bt_q        <= 1'b0;
            status_q    <= 1'b0;
        end else begin
            bt_q <= 1'b0;
            case (state_q)
                BC_IDLE: begin
                    if (start) begin
                        state_q     <= BC_SETUP;
                        rd_q        <= rd_nwr;
                        address_q   <= addr;
                        writedata_q <= data;
                    end
                end
                BC_SETUP: begin
                    state_q <= BC_PULSE;
                    cnt_q   <= 32'(E_HIGH_CYCLES - 1);
                    read_q  <= rd_q;
                    write_q <= !rd_q;
                    bt_q    <= 1'b1;
                end
                BC_PULSE: begin
                    if (cnt_q == 32'd0) begin
                        state_q  <= BC_GAP;
                        cnt_q    <= 32'(E_GAP_CYCLES - 1);
                        read_q   <= 1'b0;
                        write_q  <= 1'b0;
                        status_q <= avm_readdata[7];
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                BC_GAP: begin
                    if (cnt_q == 32'd0) begin
                        state_q     <= BC_IDLE;
                        address_q   <= '0;
                        writedata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                default: state_q <= BC_IDLE;
            endcase
        end
    end

    assign done              = (state_q == BC_GAP) && (cnt_q == 32'd0);
    assign status            = status_q;
    assign avm_address       = address_q;
    assign avm_read          = read_q;
    assign avm_write         = write_q;
    assign avm_begintransfer = bt_q;
    assign avm_writedata     = writedata_q;

endmodule

// File: rtl/lcd_text_sequencer.sv
// HD44780 text sequencer: power-up init, byte stream to timed bus cycles, cursor wrap/newline tracking.
// LCD_BUSY_POLL_EN: poll the busy flag before each post-init access instead of fixed waits.
module lcd_text_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES    = 2000000,
    parameter int unsigned E_HIGH_CYCLES     = 12,
    parameter int unsigned E_GAP_CYCLES      = 25,
    parameter int unsigned CMD_WAIT_CYCLES   = 2500,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100000,
    parameter int unsigned COLS              = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_is_cmd,
    output logic [1:0] avm_address,
    output logic       avm_read,
    output logic       avm_write,
    output logic       avm_begintransfer,
    output logic [7:0] avm_writedata,
    input  logic [7:0] avm_readdata,
    output logic       init_done,
    output logic       busy
);

    seq_state_t  state_q;
    logic [31:0] cnt_q;
    logic [1:0]  init_idx_q;
    logic        init_done_q;
    logic [7:0]  col_q;
    logic        line_q;
    logic        start_q;
    logic        bus_rd_q;
    logic [1:0]  bus_addr_q;
    logic [7:0]  bus_data_q;
    logic [1:0]  op_addr_q;
    logic [7:0]  op_data_q;
    logic        op_clear_q;
    logic        cursor_pend_q;
    logic        bus_done;
    logic        bus_status;

    lcd_bus_cycle #(
        .E_HIGH_CYCLES (E_HIGH_CYCLES),
        .E_GAP_CYCLES  (E_GAP_CYCLES)
    ) u_bus (
        .clk               (clk),
        .reset             (reset),
        .start             (start_q),
        .rd_nwr            (bus_rd_q),
        .addr              (bus_addr_q),
        .data              (bus_data_q),
        .done              (bus_done),
        .status            (bus_status),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_begintransfer (avm_begintransfer),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_PWRUP;
            cnt_q         <= 32'(POWERUP_CYCLES - 1);
            init_idx_q    <= '0;
            init_done_q   <= 1'b0;
            col_q         <= '0;
            line_q        <= 1'b0;
            start_q       <= 1'b0;
            bus_rd_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_data_q    <= '0;
            op_addr_q     <= '0;
            op_data_q     <= '0;
            op_clear_q    <= 1'b0;
            cursor_pend_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_PWRUP: begin
                    if (cnt_q == 32'd0) state_q <= ST_INIT_ISSUE;
                    else                cnt_q   <= cnt_q - 32'd1;
                end
                ST_INIT_ISSUE: begin
                    start_q    <= 1'b1;
                    bus_rd_q   <= 1'b0;
                    bus_addr_q <= ADDR_CMD_WR;
                    bus_data_q <= init_cmd(init_idx_q);
                    state_q    <= ST_INIT_BUS;
                end
                ST_INIT_BUS: begin
                    if (bus_done) begin
                        cnt_q   <= 32'(CLEAR_WAIT_CYCLES - 1);
                        state_q <= ST_INIT_WAIT;
                    end
                end
                ST_INIT_WAIT: begin
                    if (cnt_q != 32'd0) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else if (init_idx_q == 2'd3) begin
                        init_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        init_idx_q <= init_idx_q + 2'd1;
                        state_q    <= ST_INIT_ISSUE;
                    end
                end
                ST_IDLE: begin
                    if (s_valid) begin
                        state_q       <= ST_ISSUE;
                        cursor_pend_q <= 1'b0;
                        op_clear_q    <= 1'b0;
                        if (s_is_cmd) begin
                            op_addr_q <= ADDR_CMD_WR;
                            op_data_q <= s_data;
                            if (is_home_cmd(s_data)) begin
                                op_clear_q <= 1'b1;
                                col_q      <= '0;
                                line_q     <= 1'b0;
                            end
                        end else if (s_data == CHAR_NEWLINE) begin
                            // Newline is only a cursor move: the DDRAM command is the access itself.
                            op_addr_q <= ADDR_CMD_WR;
                            op_data_q <= ddram_cmd(!line_q);
                            col_q     <= '0;
                            line_q    <= !line_q;
                        end else begin
                            op_addr_q <= ADDR_DATA_WR;
                            op_data_q <= s_data;
                            if (col_q == 8'(COLS - 1)) begin
                                col_q         <= '0;
                                line_q        <= !line_q;
                                cursor_pend_q <= 1'b1;
                            end else begin
                                col_q <= col_q + 8'd1;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    start_q <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
                    bus_rd_q   <= 1'b1;
                    bus_addr_q <= ADDR_STATUS_RD;
                    bus_data_q <= '0;
                    state_q    <= ST_POLL;
`else
                    bus_rd_q   <= 1'b0;
                    bus_addr_q <= op_addr_q;
                    bus_data_q <= op_data_q;
                    state_q    <= ST_BUS;
`endif
                end
                ST_POLL: begin
                    // Busy repeats the identical status read; ready launches the pending write.
                    if (bus_done) begin
                        start_q <= 1'b1;
                        if (!bus_status) begin
                            bus_rd_q   <= 1'b0;
                            bus_addr_q <= op_addr_q;
                            bus_data_q <= op_data_q;
                            state_q    <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
`ifdef LCD_BUSY_POLL_EN
                        if (cursor_pend_q) begin
                            cursor_pend_q <= 1'b0;
                            op_addr_q     <= ADDR_CMD_WR;
                            op_data_q     <= ddram_cmd(line_q);
                            op_clear_q    <= 1'b0;
                            state_q       <= ST_ISSUE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
`else
                        cnt_q   <= op_clear_q ? 32'(CLEAR_WAIT_CYCLES - 1) : 32'(CMD_WAIT_CYCLES - 1);
                        state_q <= ST_WAIT;
`endif
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 32'd0) begin
                        cnt_q <= cnt_q - 32'd1;
                    end else if (cursor_pend_q) begin
                        // line_q already points at the new line after the wrap.
                        cursor_pend_q <= 1'b0;
                        op_addr_q     <= ADDR_CMD_WR;
                        op_data_q     <= ddram_cmd(line_q);
                        op_clear_q    <= 1'b0;
                        state_q       <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_PWRUP;
            endcase
        end
    end

    assign s_ready   = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign init_done = init_done_q;

endmodule
